// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/ack_wait_timer.sv
// Counts memory ack wait cycles; expired flags the last allowed wait cycle.
module ack_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_cnt;

  // Never wraps: the arbiter leaves ACCESS as soon as expired is seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_cnt <= '0;
    else if (i_clear)  r_cnt <= '0;
    else if (i_enable) r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (r_cnt == CW'(MAX_WAIT - 1));
endmodule

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory between CPU and loader.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err,
  output logic              owner
);
  state_t r_state, w_state_nxt;

  logic              r_mem_en, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_cpu_rdata, r_ld_rdata;
  logic              r_cpu_done, r_ld_done, r_err;
  logic              r_owner, r_last_owner;

  logic w_grant, w_grant_ld, w_expired, w_finish, w_tmr_clr, w_tmr_en;

  // LD wins alone, or on a tie when the CPU was served last.
  assign w_grant    = (r_state == ST_IDLE) && (cpu_req || ld_req);
  assign w_grant_ld = ld_req && (!cpu_req || (r_last_owner == OWN_CPU));
  assign w_finish   = mem_ack || w_expired;
  assign w_tmr_clr  = w_grant;
  assign w_tmr_en   = (r_state == ST_ACCESS) && !w_finish;

  ack_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_tmr_clr),
    .i_enable (w_tmr_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant)  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (w_finish) w_state_nxt = ST_DONE;
      ST_DONE:                 w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rdata  <= '0;
      r_ld_rdata   <= '0;
      r_cpu_done   <= 1'b0;
      r_ld_done    <= 1'b0;
      r_err        <= 1'b0;
      r_owner      <= OWN_CPU;
      r_last_owner <= OWN_LD;
    end else begin
      r_cpu_done <= 1'b0;
      r_ld_done  <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_grant) begin
          r_mem_en    <= 1'b1;
          r_owner     <= w_grant_ld;
          r_mem_we    <= w_grant_ld ? ld_we    : cpu_we;
          r_mem_addr  <= w_grant_ld ? ld_addr  : cpu_addr;
          r_mem_wdata <= w_grant_ld ? ld_wdata : cpu_wdata;
        end
        ST_ACCESS: if (w_finish) begin
          r_mem_en   <= 1'b0;
          r_mem_we   <= 1'b0;
          r_cpu_done <= (r_owner == OWN_CPU);
          r_ld_done  <= (r_owner == OWN_LD);
          r_err      <= !mem_ack;
          // Timeouts and writes leave the owner's read data untouched.
          if (mem_ack && !r_mem_we) begin
            if (r_owner == OWN_LD) r_ld_rdata  <= mem_rdata;
            else                   r_cpu_rdata <= mem_rdata;
          end
        end
        ST_DONE: r_last_owner <= r_owner;
        default: ;
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign ld_rdata  = r_ld_rdata;
  assign cpu_done  = r_cpu_done;
  assign ld_done   = r_ld_done;
  assign err       = r_err;
  assign owner     = r_owner;
  assign cpu_stall = cpu_req && !r_cpu_done;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter.
module tb_unified_mem_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done, cpu_stall;
  logic              ld_req = 1'b0, ld_we = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_wdata = '0;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_done;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic              err, owner;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_done(ld_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err), .owner(owner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_en"},    32'(mem_en),    32'h0);
    check({tag, "_mem_we"},    32'(mem_we),    32'h0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
    check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'h0);
    check({tag, "_ld_rdata"},  32'(ld_rdata),  32'h0);
    check({tag, "_cpu_done"},  32'(cpu_done),  32'h0);
    check({tag, "_ld_done"},   32'(ld_done),   32'h0);
    check({tag, "_err"},       32'(err),       32'h0);
    check({tag, "_owner"},     32'(owner),     32'h0);
    check({tag, "_cpu_stall"}, 32'(cpu_stall), 32'h0);
  endtask

  initial begin
    logic exp_own;

    // Reset values, during and after reset
    repeat (2) @(negedge clk);
    check_idle_outputs("rst_low");
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_rel");

    // CPU read, ack in the first en cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    mem_ack = 1'b1; mem_rdata = 16'hA5C3;
    #1 check("rd_stall_c0", 32'(cpu_stall), 32'h1);
    @(negedge clk);
    check("rd_en_c1",    32'(mem_en),    32'h1);
    check("rd_we_c1",    32'(mem_we),    32'h0);
    check("rd_addr_c1",  32'(mem_addr),  32'h010);
    check("rd_stall_c1", 32'(cpu_stall), 32'h1);
    check("rd_done_c1",  32'(cpu_done),  32'h0);
    @(negedge clk);
    check("rd_en_c2",    32'(mem_en),    32'h0);
    check("rd_done_c2",  32'(cpu_done),  32'h1);
    check("rd_data_c2",  32'(cpu_rdata), 32'hA5C3);
    check("rd_stall_c2", 32'(cpu_stall), 32'h0);
    check("rd_err_c2",   32'(err),       32'h0);
    check("rd_owner_c2", 32'(owner),     32'h0);
    cpu_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check("rd_done_c3",  32'(cpu_done),  32'h0);
    check("rd_en_c3",    32'(mem_en),    32'h0);

    // LD write with 3 ack wait cycles; inputs changed mid-access must not leak
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 12'hFFF; ld_wdata = 16'h1234;
    mem_rdata = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wr_en",    32'(mem_en),    32'h1);
      check("wr_we",    32'(mem_we),    32'h1);
      check("wr_addr",  32'(mem_addr),  32'hFFF);
      check("wr_wdata", 32'(mem_wdata), 32'h1234);
      check("wr_done",  32'(ld_done),   32'h0);
      check("wr_owner", 32'(owner),     32'h1);
      if (i == 1) begin ld_addr = 12'h000; ld_wdata = 16'h0000; end
      if (i == 3) mem_ack = 1'b1;
    end
    @(negedge clk);
    check("wr_en_end",   32'(mem_en),    32'h0);
    check("wr_ld_done",  32'(ld_done),   32'h1);
    check("wr_cpu_done", 32'(cpu_done),  32'h0);
    check("wr_ld_rdata", 32'(ld_rdata),  32'h0);
    check("wr_err",      32'(err),       32'h0);
    ld_req = 1'b0; ld_we = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check("wr_done_off", 32'(ld_done),   32'h0);

    // Both requesting for 4 accesses: strict alternation starting with CPU
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h020;
    ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 12'h030;
    mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_own = k[0];
      mem_rdata = 16'h1000 + 16'(k);
      @(negedge clk);
      check("rr_en",    32'(mem_en),   32'h1);
      check("rr_owner", 32'(owner),    32'(exp_own));
      check("rr_addr",  32'(mem_addr), exp_own ? 32'h030 : 32'h020);
      @(negedge clk);
      check("rr_cpu_done", 32'(cpu_done), 32'(!exp_own));
      check("rr_ld_done",  32'(ld_done),  32'(exp_own));
      check("rr_err",      32'(err),      32'h0);
      if (k == 3) begin cpu_req = 1'b0; ld_req = 1'b0; mem_ack = 1'b0; end
      @(negedge clk);
    end
    check("rr_cpu_rdata", 32'(cpu_rdata), 32'h1002);
    check("rr_ld_rdata",  32'(ld_rdata),  32'h1003);

    // Timeout: ack never comes, mem_en held for exactly MAX_WAIT cycles
    cpu_req = 1'b1; cpu_addr = 12'h040; mem_rdata = 16'hDEAD;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("to_en",   32'(mem_en),   32'h1);
      check("to_done", 32'(cpu_done), 32'h0);
      check("to_err",  32'(err),      32'h0);
    end
    @(negedge clk);
    check("to_en_end",  32'(mem_en),    32'h0);
    check("to_done_p",  32'(cpu_done),  32'h1);
    check("to_err_p",   32'(err),       32'h1);
    check("to_rdata",   32'(cpu_rdata), 32'h1002);
    cpu_req = 1'b0;
    @(negedge clk);
    check("to_err_off",  32'(err),      32'h0);
    check("to_done_off", 32'(cpu_done), 32'h0);
    ld_req = 1'b1; ld_addr = 12'h050; mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    @(negedge clk);
    check("to_idle_grant_en",    32'(mem_en), 32'h1);
    check("to_idle_grant_owner", 32'(owner),  32'h1);
    @(negedge clk);
    check("to_ld_done",  32'(ld_done),  32'h1);
    check("to_ld_rdata", 32'(ld_rdata), 32'h5A5A);
    ld_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);

    // Async reset in ACCESS drops mem_en without a clock edge, no done follows
    cpu_req = 1'b1; cpu_addr = 12'h060;
    @(negedge clk);
    check("ar_en_pre", 32'(mem_en), 32'h1);
    #2 rst = 1'b0;
    #1 check("ar_en_async", 32'(mem_en), 32'h0);
    cpu_req = 1'b0;
    @(negedge clk);
    check_idle_outputs("ar_hold");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ar_no_cpu_done", 32'(cpu_done), 32'h0);
      check("ar_no_ld_done",  32'(ld_done),  32'h0);
      check("ar_no_en",       32'(mem_en),   32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters: the multi-cycle processor port (CPU) and a program loader/debug port (LD).
- Serialises accesses and drives a variable-latency memory through an en/ack handshake.
- Returns read data and a one-cycle completion pulse to the owning requester.
- Provides a stall to the processor control unit so that PC/IR/register writes wait for memory completion.

Parameters:
- ADDR_W, 12, word address width.
- DATA_W, 16, memory word width (matches 16-bit instruction).
- MAX_WAIT, 15, maximum cycles to wait for mem_ack before aborting with error; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, held until cpu_done.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data, valid with cpu_done, held until next CPU completion.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_stall  out  1  cpu_req & ~cpu_done.
- ld_req, ld_we, ld_addr, ld_wdata, ld_rdata, ld_done  same as CPU set, for the loader port.
- mem_en  out  1  memory access strobe, held until ack.
- mem_we  out  1  memory write enable, valid with mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, may be high in the first mem_en cycle.
- err  out  1  one-cycle pulse with *_done when the access timed out.
- owner  out  1  current or last grantee: 0 = CPU, 1 = LD.

Behaviour:
- Reset (rst=0, async): state=IDLE, and every output is 0, including mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, ld_rdata, both done pulses, err and cpu_stall.
  - last_owner resets to LD, so the CPU wins the first tie.
  - Reset during ACCESS drops mem_en immediately; the in-flight access is abandoned and no done pulse is produced.
- All outputs are registered except cpu_stall.
- FSM states:
  - IDLE: no request means stay.
    - If exactly one req is high, grant it.
    - If both are high, grant the requester != last_owner (round-robin).
    - On grant: latch we/addr/wdata into mem_* registers, set owner, clear the wait counter, go to ACCESS.
  - ACCESS: mem_en=1.
    - If mem_ack: capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), go to DONE.
    - Else, if the wait counter == MAX_WAIT-1: go to DONE with err pending and rdata unchanged.
    - Else: increment the counter.
  - DONE: mem_en=0. The owner's *_done=1 for exactly this cycle; err=1 if a timeout occurred. Set last_owner=owner, go to IDLE.
- Requester contract: req is sampled only in IDLE.
  - A requester must drop or refresh req at the clock edge where it sees done.
  - req high in the cycle after done counts as a new request.
  - Requests are not cancellable once granted.
- Latency with a zero-wait memory (ack in the first en cycle):
  - req high at edge 0.
  - mem_en high in cycle 1.
  - done in cycle 2.
  - IDLE in cycle 3.
  - Each extra ack wait cycle adds 1 cycle.
- Fairness: with both requesters continuously asserting, grants strictly alternate CPU, LD, CPU, ...
- A losing requester's req and inputs are ignored until a grant; mem_addr and mem_wdata never change during ACCESS.
- mem_ack outside ACCESS is ignored.
- The wait counter is $clog2(MAX_WAIT+1) bits wide and never wraps, because the timeout exits first.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE, ACCESS, DONE);
  - owner constants OWN_CPU=0, OWN_LD=1;
  - default ADDR_W/DATA_W.
- Sub-module ack_wait_timer (clear, enable, expired at MAX_WAIT-1) is natural; everything else stays in unified_mem_arbiter.

Test Plan:
- Reset checks:
  - Reset values: after rst low→high, all outputs are 0 and cpu_stall=0.
  - rst pulse in ACCESS: mem_en falls without a clock edge and no done pulse appears.
- CPU read, ack in the first cycle: cpu_req=1, cpu_addr=0x010, mem_rdata=0xA5C3 → mem_en in cycle 1 only, cpu_done and cpu_rdata=0xA5C3 in cycle 2, cpu_stall=1 for cycles 0–1.
- LD write with 3 wait cycles: ld_we=1, ld_addr=0xFFF, ld_wdata=0x1234 → mem_en held for 4 cycles with stable addr/data, ld_done once, ld_rdata unchanged.
- Simultaneous requests held for 4 accesses → owner sequence 0,1,0,1; each done goes only to its owner; err=0.
- Timeout: mem_ack never asserted, MAX_WAIT=15 → mem_en high for exactly 15 cycles, then cpu_done=1 and err=1 in the same cycle; arbiter back in IDLE the next cycle.
